branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised branch/jump predictor for the RV32I pipeline.
- Lets IF redirect early, instead of resolving every control transfer in EX and flushing.
- Contents:
  - Direct-mapped BTB with per-entry saturating direction counters.
  - Return-address stack (RAS).
  - Mispredict detection and a mispredict counter.
- Looked up by IF every cycle; trained non-speculatively by the resolving instruction in EX.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of 2, at least 2; IDX = log2(ENTRIES)
TAG_W, 8, stored tag bits
CTR_W, 2, direction counter width, at least 1
RAS_DEPTH, 4, return stack entries; power of 2, at least 2
CNT_W, 16, mispredict counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
lookup_pc  in  XLEN  PC in IF
pred_taken  out  1  IF prediction: redirect
pred_target  out  XLEN  IF predicted next PC
upd_valid  in  1  EX holds a resolved, non-bubble control instruction
upd_pc  in  XLEN  PC of that instruction
upd_type  in  2  00 cond branch, 01 JAL/JALR non-return, 10 return, 11 none
upd_is_call  in  1  instruction writes x1/x5 (push link)
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target
upd_pred_taken  in  1  prediction carried down the pipe
upd_pred_target  in  XLEN  predicted target carried down the pipe
mispredict  out  1  EX redirect required
mispred_cnt  out  CNT_W  saturating count of mispredicts

Behaviour:
- Index and tag
  - idx = pc[IDX+1:2]; tag = pc[IDX+TAG_W+1:IDX+2].
  - Entry fields: valid, tag, type(2), target(XLEN), ctr(CTR_W).
- Lookup: combinational from registered state, zero latency.
  - hit = valid and tag match.
  - Miss: pred_taken=0, pred_target=lookup_pc+4.
  - Hit, type 00: pred_taken = ctr MSB; pred_target = target if taken, else lookup_pc+4.
  - Hit, type 01: pred_taken=1, pred_target = stored target.
  - Hit, type 10: pred_taken=1; pred_target = RAS top if ras_cnt>0, else stored target.
- mispredict (combinational)
  - Asserted when upd_valid and upd_type!=11, and either:
    - upd_taken != upd_pred_taken, or
    - upd_taken and upd_target != upd_pred_target.
  - Forced to 0 when upd_valid=0 or upd_type=11.
- Update on posedge when upd_valid and upd_type!=11
  - Hit, type 00:
    - ctr saturating +1 if taken, -1 if not taken; no wrap at all-ones or zero.
    - target written when taken.
  - Miss and taken: allocate and overwrite the resident entry.
    - valid=1; tag, type and target written.
    - ctr = 2^(CTR_W-1) for type 00, all-ones otherwise.
  - Miss and not taken: no allocation.
  - Hit, type 01/10: target and type rewritten.
- RAS (trained at EX; non-speculative)
  - Call: push upd_pc+4; ptr=ptr+1 mod RAS_DEPTH; ras_cnt=min(ras_cnt+1, RAS_DEPTH).
    - Overflow overwrites the oldest entry.
  - type 10: pop; ptr=ptr-1; ras_cnt=ras_cnt-1.
    - Pop with ras_cnt=0 is ignored (no pointer move).
  - Call and return in the same update: pop then push (top replaced, ras_cnt unchanged).
- mispred_cnt increments on each posedge with mispredict=1; saturates at all-ones.
- Same-cycle lookup and update of the same idx: lookup returns pre-update contents; the update is visible next cycle.
- Reset (rst=0 at posedge, wins over update):
  - All valid=0, ctr=0, RAS ptr=0, ras_cnt=0, mispred_cnt=0.
  - Outputs after reset: pred_taken=0, pred_target=lookup_pc+4, mispredict per its equation.
- Reset mid-training discards that cycle's update.

Test Plan:
- Reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, mispred_cnt=0.
- Cond branch at 0x200, taken to 0x180, updated with pred_taken=0:
  - mispredict=1 during the update; mispred_cnt=1.
  - Next-cycle lookup 0x200 -> pred_taken=1, pred_target=0x180 (ctr=10).
- Train 0x200 not-taken twice from ctr=10 -> ctr 01 then 00, pred_taken=0; a third not-taken holds 00. Four taken from 00 -> saturates at 11.
- Aliasing, ENTRIES=16: 0x040 and 0x440 (same idx, different tag) taken alternately -> each allocation evicts the other; lookup of the evicted PC misses.
- RAS:
  - Calls at 0x300, 0x310, 0x320, 0x330, 0x340 (depth 4) -> overflow.
  - Return entry at 0x500 hit -> pred_target sequence on successive pops: 0x344, 0x334, 0x324, 0x314.
  - Fifth pop with ras_cnt=0 -> stored BTB target.
- Same-cycle lookup and update of 0x200 -> lookup shows old value, new value the next cycle.
- rst=0 with upd_valid=1 -> no entry written and mispred_cnt=0.

Source files
------------

// File: rtl/branch_predictor.sv
// RV32I front-end predictor: direct-mapped BTB with saturating direction counters,
// a return-address stack trained from EX, and mispredict detection/counting.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_type,
  input  logic            upd_is_call,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int RP  = $clog2(RAS_DEPTH);
  localparam logic [CTR_W-1:0] CTR_MID  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [RP:0]      RAS_FULL = (RP+1)'(RAS_DEPTH);

  localparam logic [1:0] T_COND = 2'b00;
  localparam logic [1:0] T_JMP  = 2'b01;
  localparam logic [1:0] T_RET  = 2'b10;
  localparam logic [1:0] T_NONE = 2'b11;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ty;
    logic [XLEN-1:0]  tgt;
    logic [CTR_W-1:0] ctr;
  } btb_t;

  btb_t            btb_q [ENTRIES];
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [RP-1:0]   ras_ptr_q, ras_ptr_d;
  logic [RP:0]     ras_cnt_q, ras_cnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  // ---------------- lookup ----------------
  logic [IDX-1:0]   l_idx;
  logic [TAG_W-1:0] l_tag;
  btb_t             l_ent;
  logic             l_hit;
  logic [XLEN-1:0]  l_pc4, ras_top;

  assign l_idx   = lookup_pc[IDX+1:2];
  assign l_tag   = lookup_pc[IDX+TAG_W+1:IDX+2];
  assign l_ent   = btb_q[l_idx];
  assign l_hit   = l_ent.vld && (l_ent.tag == l_tag);
  assign l_pc4   = lookup_pc + XLEN'(4);
  assign ras_top = ras_q[ras_ptr_q - RP'(1)];

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = l_pc4;
    if (l_hit) begin
      case (l_ent.ty)
        T_COND: begin
          pred_taken = l_ent.ctr[CTR_W-1];
          if (l_ent.ctr[CTR_W-1]) pred_target = l_ent.tgt;
        end
        T_JMP: begin
          pred_taken  = 1'b1;
          pred_target = l_ent.tgt;
        end
        T_RET: begin
          pred_taken  = 1'b1;
          pred_target = (ras_cnt_q != '0) ? ras_top : l_ent.tgt;
        end
        default: ;
      endcase
    end
  end

  // ---------------- resolve / train ----------------
  logic             upd_en;
  logic [IDX-1:0]   u_idx;
  logic [TAG_W-1:0] u_tag;
  btb_t             u_ent, ent_d;
  logic             u_hit, wr_en;

  assign upd_en     = upd_valid && (upd_type != T_NONE);
  assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                 (upd_taken && (upd_target != upd_pred_target)));
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[IDX+TAG_W+1:IDX+2];
  assign u_ent = btb_q[u_idx];
  assign u_hit = u_ent.vld && (u_ent.tag == u_tag);

  always_comb begin
    ent_d = u_ent;
    wr_en = 1'b0;
    if (upd_en) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_type == T_COND) begin
          if (upd_taken) begin
            ent_d.tgt = upd_target;
            if (u_ent.ctr != '1) ent_d.ctr = u_ent.ctr + CTR_W'(1);
          end else if (u_ent.ctr != '0) begin
            ent_d.ctr = u_ent.ctr - CTR_W'(1);
          end
        end else begin
          ent_d.ty  = upd_type;
          ent_d.tgt = upd_target;
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever lives at this index.
        wr_en     = 1'b1;
        ent_d.vld = 1'b1;
        ent_d.tag = u_tag;
        ent_d.ty  = upd_type;
        ent_d.tgt = upd_target;
        ent_d.ctr = (upd_type == T_COND) ? CTR_MID : '1;
      end
    end
  end

  // RAS: pop first, then push, so call+return replaces the top in place.
  logic          do_pop, do_push;
  logic [RP-1:0] ptr_p;
  logic [RP:0]   cnt_p;
  logic [XLEN-1:0] push_val;

  assign do_pop   = upd_en && (upd_type == T_RET) && (ras_cnt_q != '0);
  assign do_push  = upd_en && upd_is_call;
  assign ptr_p    = do_pop ? ras_ptr_q - RP'(1) : ras_ptr_q;
  assign cnt_p    = do_pop ? ras_cnt_q - (RP+1)'(1) : ras_cnt_q;
  assign push_val = upd_pc + XLEN'(4);

  always_comb begin
    ras_ptr_d = ptr_p;
    ras_cnt_d = cnt_p;
    if (do_push) begin
      ras_ptr_d = ptr_p + RP'(1);
      if (cnt_p != RAS_FULL) ras_cnt_d = cnt_p + (RP+1)'(1);
    end
  end

  assign mcnt_d = (mispredict && (mcnt_q != '1)) ? mcnt_q + CNT_W'(1) : mcnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      mcnt_q    <= '0;
    end else begin
      if (wr_en)   btb_q[u_idx] <= ent_d;
      if (do_push) ras_q[ptr_p] <= push_val;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign mispred_cnt = mcnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expected outputs into a
// scoreboard, a negedge monitor pops and compares them.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_is_call;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [2:0]  mispred_cnt;

  always #5 clk = ~clk;

  // Narrow counter so saturation is reachable in a few cycles.
  branch_predictor #(.CNT_W(3)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type),
    .upd_is_call(upd_is_call), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic v; logic [31:0] pc; logic [1:0] ty; logic call; logic tk;
    logic [31:0] tgt; logic ppt; logic [31:0] ptgt;
  } upd_t;

  typedef struct {
    string nm; int cyc; logic pt; logic [31:0] tgt; logic mp; logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int cyc_no = 0;
  int n_run  = 0;
  int n_fail = 0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  function automatic upd_t U(logic [31:0] pc, logic [1:0] ty, logic call, logic tk,
                             logic [31:0] tgt, logic ppt, logic [31:0] ptgt);
    upd_t r;
    r.v = 1'b1; r.pc = pc; r.ty = ty; r.call = call; r.tk = tk;
    r.tgt = tgt; r.ppt = ppt; r.ptgt = ptgt;
    return r;
  endfunction

  function automatic upd_t NOU();
    upd_t r;
    r = U(32'h0, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEE0, 1'b0, 32'h0);
    r.v = 1'b0;
    return r;
  endfunction

  task automatic step(string nm, logic [31:0] lpc, upd_t u,
                      logic ept, logic [31:0] etgt, logic emp, logic [2:0] ecnt);
    exp_t e;
    lookup_pc = lpc;
    upd_valid = u.v; upd_pc = u.pc; upd_type = u.ty; upd_is_call = u.call;
    upd_taken = u.tk; upd_target = u.tgt; upd_pred_taken = u.ppt; upd_pred_target = u.ptgt;
    e.nm = nm; e.cyc = cyc_no; e.pt = ept; e.tgt = etgt; e.mp = emp; e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc == cyc_no) begin
      e = sb.pop_front();
      n_run++;
      if (pred_taken !== e.pt || pred_target !== e.tgt ||
          mispredict !== e.mp || mispred_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got pt=%0b tgt=%h mp=%0b cnt=%0d, expected pt=%0b tgt=%h mp=%0b cnt=%0d",
                 e.nm, pred_taken, pred_target, mispredict, mispred_cnt,
                 e.pt, e.tgt, e.mp, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    step("pre", 32'h0, NOU(), 1'b0, 32'h4, 1'b0, 3'd0);
    sb.delete();
    n_run = 0;
    // Reset held while an update is presented: nothing may be written.
    step("rst_upd",   32'h100, U(32'h100, 2'b00, 0, 1, 32'h180, 0, 32'h104), 0, 32'h104, 1, 0);
    rst = 1'b1;
    step("rst_state", 32'h100, NOU(), 0, 32'h104, 0, 0);

    // Conditional branch at 0x200 training.
    step("c1_alloc",  32'h200, U(32'h200, 2'b00, 0, 1, 32'h180, 0, 32'h204), 0, 32'h204, 1, 0);
    step("c2_same",   32'h200, U(32'h200, 2'b00, 0, 0, 32'h204, 1, 32'h180), 1, 32'h180, 1, 1);
    step("c3_ctr01",  32'h200, U(32'h200, 2'b00, 0, 0, 32'h204, 0, 32'h204), 0, 32'h204, 0, 2);
    step("c4_ctr00",  32'h200, U(32'h200, 2'b00, 0, 0, 32'h204, 0, 32'h204), 0, 32'h204, 0, 2);
    step("c5_hold00", 32'h200, U(32'h200, 2'b00, 0, 1, 32'h180, 0, 32'h204), 0, 32'h204, 1, 2);
    step("c6_ctr01",  32'h200, U(32'h200, 2'b00, 0, 1, 32'h180, 0, 32'h204), 0, 32'h204, 1, 3);
    step("c7_ctr10",  32'h200, U(32'h200, 2'b00, 0, 1, 32'h180, 1, 32'h180), 1, 32'h180, 0, 4);
    step("c8_ctr11",  32'h200, U(32'h200, 2'b00, 0, 1, 32'h180, 1, 32'h180), 1, 32'h180, 0, 4);
    step("c9_sat11",  32'h200, U(32'h200, 2'b00, 0, 0, 32'h204, 1, 32'h180), 1, 32'h180, 1, 4);
    step("c10_ctr10", 32'h200, NOU(), 1, 32'h180, 0, 5);
    step("c11_tgtmp", 32'h200, U(32'h200, 2'b00, 0, 1, 32'h1C0, 1, 32'h180), 1, 32'h180, 1, 5);
    step("c12_newtg", 32'h200, U(32'h200, 2'b11, 0, 1, 32'h999, 0, 32'h0),   1, 32'h1C0, 0, 6);
    step("c13_novld", 32'h200, U(32'h200, 2'b00, 0, 1, 32'h999, 0, 32'h0),   1, 32'h1C0, 1, 6);
    // c13 mispredicted the real update; restore expectation bookkeeping via a check
    step("c14_after", 32'h200, NOU(), 1, 32'h999, 0, 7);
    rst = 1'b0;
    step("rst2",      32'h200, NOU(), 1, 32'h999, 0, 7);
    rst = 1'b1;
    step("rst2_chk",  32'h200, NOU(), 0, 32'h204, 0, 0);

    // Aliasing at idx 0.
    step("a1", 32'h040, U(32'h040, 2'b00, 0, 1, 32'h080, 1, 32'h080), 0, 32'h044, 0, 0);
    step("a2", 32'h040, U(32'h440, 2'b00, 0, 1, 32'h480, 1, 32'h480), 1, 32'h080, 0, 0);
    step("a3", 32'h440, NOU(), 1, 32'h480, 0, 0);
    step("a4", 32'h040, U(32'h040, 2'b00, 0, 1, 32'h080, 1, 32'h080), 0, 32'h044, 0, 0);
    step("a5", 32'h440, NOU(), 0, 32'h444, 0, 0);
    step("a6", 32'h040, NOU(), 1, 32'h080, 0, 0);

    // RAS: return entry first (pop on empty stack ignored), then five calls.
    step("r0", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 1, 32'h900), 0, 32'h508, 0, 0);
    step("r1", 32'h504, NOU(), 1, 32'h900, 0, 0);
    step("k1", 32'h504, U(32'h300, 2'b01, 1, 1, 32'h800, 1, 32'h800), 1, 32'h900, 0, 0);
    step("k2", 32'h504, U(32'h310, 2'b01, 1, 1, 32'h800, 1, 32'h800), 1, 32'h304, 0, 0);
    step("k3", 32'h504, U(32'h320, 2'b01, 1, 1, 32'h800, 1, 32'h800), 1, 32'h314, 0, 0);
    step("k4", 32'h504, U(32'h330, 2'b01, 1, 1, 32'h800, 1, 32'h800), 1, 32'h324, 0, 0);
    step("k5", 32'h504, U(32'h340, 2'b01, 1, 1, 32'h800, 1, 32'h800), 1, 32'h334, 0, 0);
    step("p1", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 1, 32'h900), 1, 32'h344, 0, 0);
    step("p2", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 1, 32'h900), 1, 32'h334, 0, 0);
    step("p3", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 1, 32'h900), 1, 32'h324, 0, 0);
    step("p4", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 1, 32'h900), 1, 32'h314, 0, 0);
    step("p5", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 1, 32'h900), 1, 32'h900, 0, 0);
    step("p6", 32'h504, NOU(), 1, 32'h900, 0, 0);
    // Call and return in one update replaces the top without changing depth.
    step("s1", 32'h504, U(32'h600, 2'b01, 1, 1, 32'h800, 1, 32'h800), 1, 32'h900, 0, 0);
    step("s2", 32'h504, U(32'h610, 2'b10, 1, 1, 32'h700, 1, 32'h700), 1, 32'h604, 0, 0);
    step("s3", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 1, 32'h900), 1, 32'h614, 0, 0);
    step("s4", 32'h504, NOU(), 1, 32'h900, 0, 0);

    // Mispredict counter saturation (3-bit).
    for (int i = 0; i < 8; i++)
      step("x_cnt", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 0, 32'h900), 1, 32'h900, 1, 3'(i));
    step("x_sat", 32'h504, U(32'h504, 2'b10, 0, 1, 32'h900, 0, 32'h900), 1, 32'h900, 1, 7);
    step("x_hold", 32'h504, NOU(), 1, 32'h900, 0, 7);

    // Reset mid-training discards the update.
    rst = 1'b0;
    step("m1", 32'h504, U(32'h504, 2'b01, 0, 1, 32'hA00, 0, 32'h0), 1, 32'h900, 1, 7);
    rst = 1'b1;
    step("m2", 32'h504, NOU(), 0, 32'h508, 0, 0);

    @(negedge clk);
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
